// File: rtl/battle_pkg.sv
// battle_pkg: shared move/winner encodings and FSM state type for the battle turn sequencer
package battle_pkg;
  localparam logic [1:0] PUNCH = 2'b00, KICK = 2'b01, BAT = 2'b10, SWORD = 2'b11;
  localparam logic [1:0] WIN_NONE = 2'b00, WIN_PLAYER = 2'b01, WIN_ENEMY = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE, S_P_WAIT, S_P_STRIKE, S_P_DMG, S_E_REQ, S_E_WAIT, S_E_STRIKE, S_E_DMG, S_DONE
  } state_e;
endpackage

// File: rtl/battle_turn_ctrl_hp_pool.sv
// hp_pool: 8-bit HP register with load-to-max, saturating damage apply and an "emptied by dmg_i" flag
//   load_i  : reload MAX_HP (wins over apply_i)
//   apply_i : subtract dmg_i, clamping at zero
//   empty_o : current dmg_i would leave the pool at zero
module hp_pool #(
  parameter logic [7:0] MAX_HP = 8'd100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       apply_i,
  input  logic [7:0] dmg_i,
  output logic [7:0] hp_o,
  output logic       empty_o
);
  logic [7:0] hp_q, hp_d;
  assign hp_d    = load_i ? MAX_HP : apply_i ? (hp_q > dmg_i ? hp_q - dmg_i : 8'd0) : hp_q;
  assign empty_o = hp_q <= dmg_i;
  assign hp_o    = hp_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hp_q <= MAX_HP;
    else hp_q <= hp_d;
endmodule

// File: rtl/battle_turn_ctrl.sv
// battle_turn_ctrl: alternates player/enemy turns, issues strike pulses and applies returned damage
//   in : start, p_move_valid/p_move, e_move_valid/e_move, dmg_e/dmg_e_vld, dmg_p/dmg_p_vld
//   out: e_move_req, att_e_en/attack_e, att_p_en/attack_p, hp_p_left, hp_e_left,
//        player_turn, busy, game_over, winner, turn_cnt, dmg_timeout_err
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int unsigned P_MAX_HP    = 100,
  parameter int unsigned E_MAX_HP    = 100,
  parameter int unsigned DMG_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       p_move_valid,
  input  logic [1:0] p_move,
  output logic       e_move_req,
  input  logic       e_move_valid,
  input  logic [1:0] e_move,
  output logic       att_e_en,
  output logic [1:0] attack_e,
  output logic       att_p_en,
  output logic [1:0] attack_p,
  input  logic [7:0] dmg_e,
  input  logic       dmg_e_vld,
  input  logic [7:0] dmg_p,
  input  logic       dmg_p_vld,
  output logic [7:0] hp_p_left,
  output logic [7:0] hp_e_left,
  output logic       player_turn,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] turn_cnt,
  output logic       dmg_timeout_err
);
  localparam logic [7:0] TMO_LAST = 8'(DMG_TIMEOUT - 1);
  state_e     state_q;
  logic [1:0] attack_e_q, attack_p_q, winner_q;
  logic [7:0] turn_q, tmo_q;
  logic       err_q;
  logic       load, tmo_hit, apply_e, apply_p, empty_e, empty_p;
  logic [7:0] dmg_e_eff, dmg_p_eff;
  assign load      = start && (state_q == S_IDLE || state_q == S_DONE);
  assign tmo_hit   = tmo_q == TMO_LAST;
  // a timed-out strike is applied as 0 damage
  assign dmg_e_eff = dmg_e_vld ? dmg_e : 8'd0;
  assign dmg_p_eff = dmg_p_vld ? dmg_p : 8'd0;
  assign apply_e   = state_q == S_P_DMG && (dmg_e_vld || tmo_hit);
  assign apply_p   = state_q == S_E_DMG && (dmg_p_vld || tmo_hit);
  hp_pool #(.MAX_HP(8'(E_MAX_HP))) u_pool_e (
    .clk(clk), .rst_n(rst_n), .load_i(load), .apply_i(apply_e),
    .dmg_i(dmg_e_eff), .hp_o(hp_e_left), .empty_o(empty_e)
  );
  hp_pool #(.MAX_HP(8'(P_MAX_HP))) u_pool_p (
    .clk(clk), .rst_n(rst_n), .load_i(load), .apply_i(apply_p),
    .dmg_i(dmg_p_eff), .hp_o(hp_p_left), .empty_o(empty_p)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      attack_e_q <= PUNCH;
      attack_p_q <= PUNCH;
      winner_q   <= WIN_NONE;
      turn_q     <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_q  <= S_P_WAIT;
          winner_q <= WIN_NONE;
          turn_q   <= '0;
          err_q    <= 1'b0;
        end
        S_P_WAIT: if (p_move_valid) begin
          attack_e_q <= p_move;
          state_q    <= S_P_STRIKE;
        end
        S_P_STRIKE: begin
          tmo_q   <= '0;
          state_q <= S_P_DMG;
        end
        S_P_DMG: if (apply_e) begin
          state_q <= empty_e ? S_DONE : S_E_REQ;
          if (empty_e) winner_q <= WIN_PLAYER;
          if (!dmg_e_vld) err_q <= 1'b1;
        end else tmo_q <= tmo_q + 8'd1;
        S_E_REQ: state_q <= S_E_WAIT;
        S_E_WAIT: if (e_move_valid) begin
          attack_p_q <= e_move;
          state_q    <= S_E_STRIKE;
        end
        S_E_STRIKE: begin
          tmo_q   <= '0;
          state_q <= S_E_DMG;
        end
        S_E_DMG: if (apply_p) begin
          state_q <= empty_p ? S_DONE : S_P_WAIT;
          if (empty_p) winner_q <= WIN_ENEMY;
          else if (turn_q != 8'hff) turn_q <= turn_q + 8'd1;
          if (!dmg_p_vld) err_q <= 1'b1;
        end else tmo_q <= tmo_q + 8'd1;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign e_move_req      = state_q == S_E_REQ;
  assign att_e_en        = state_q == S_P_STRIKE;
  assign att_p_en        = state_q == S_E_STRIKE;
  assign attack_e        = attack_e_q;
  assign attack_p        = attack_p_q;
  assign player_turn     = state_q == S_P_WAIT || state_q == S_P_STRIKE || state_q == S_P_DMG;
  assign busy            = state_q != S_IDLE && state_q != S_DONE;
  assign game_over       = state_q == S_DONE;
  assign winner          = winner_q;
  assign turn_cnt        = turn_q;
  assign dmg_timeout_err = err_q;
endmodule

// File: tb/tb_battle_turn_ctrl.sv
// tb_battle_turn_ctrl: scoreboard bench for battle_turn_ctrl
module tb_battle_turn_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic p_move_valid = 1'b0, e_move_valid = 1'b0, dmg_e_vld = 1'b0, dmg_p_vld = 1'b0;
  logic [1:0] p_move = '0, e_move = '0;
  logic [7:0] dmg_e = '0, dmg_p = '0;
  logic e_move_req, att_e_en, att_p_en, player_turn, busy, game_over, dmg_timeout_err;
  logic [1:0] attack_e, attack_p, winner;
  logic [7:0] hp_p_left, hp_e_left, turn_cnt;
  battle_turn_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .p_move_valid(p_move_valid), .p_move(p_move), .e_move_req(e_move_req),
    .e_move_valid(e_move_valid), .e_move(e_move),
    .att_e_en(att_e_en), .attack_e(attack_e), .att_p_en(att_p_en), .attack_p(attack_p),
    .dmg_e(dmg_e), .dmg_e_vld(dmg_e_vld), .dmg_p(dmg_p), .dmg_p_vld(dmg_p_vld),
    .hp_p_left(hp_p_left), .hp_e_left(hp_e_left), .player_turn(player_turn), .busy(busy),
    .game_over(game_over), .winner(winner), .turn_cnt(turn_cnt), .dmg_timeout_err(dmg_timeout_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] hp_p, hp_e, turn;
    logic       over, err;
    logic [1:0] win;
    int         lat;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;
  logic [7:0] m_hp_p = 8'd100, m_hp_e = 8'd100, m_turn = '0;
  logic       m_err = 1'b0, m_over = 1'b0;
  logic [1:0] m_win = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_hp_p"}, hp_p_left, 8'd100);
    chk({tag, "_hp_e"}, hp_e_left, 8'd100);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_win"}, winner, 0);
    chk({tag, "_turn"}, turn_cnt, 0);
    chk({tag, "_err"}, dmg_timeout_err, 0);
    chk({tag, "_en"}, {att_e_en, att_p_en, e_move_req, player_turn}, 0);
    chk({tag, "_codes"}, {attack_e, attack_p}, 0);
  endtask
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_hp_p = 8'd100; m_hp_e = 8'd100; m_turn = '0; m_err = 1'b0; m_win = '0; m_over = 1'b0;
    chk("start_hp", {hp_p_left, hp_e_left}, {8'd100, 8'd100});
    chk("start_flags", {busy, player_turn, game_over, winner, dmg_timeout_err, turn_cnt}, {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0});
  endtask
  task automatic turn(input bit enemy, input logic [1:0] mv, input logic [7:0] dmg, input bit vld);
    exp_t e, got;
    logic [7:0] old, d, nw;
    int lat;
    if (enemy) begin
      @(negedge clk);
      chk("req_one_cycle", e_move_req, 0);
      e_move_valid = 1'b1; e_move = mv;
    end else begin
      p_move_valid = 1'b1; p_move = mv;
    end
    @(negedge clk);
    p_move_valid = 1'b0; e_move_valid = 1'b0;
    chk(enemy ? "att_p_en" : "att_e_en", enemy ? att_p_en : att_e_en, 1);
    chk("att_other", enemy ? att_e_en : att_p_en, 0);
    chk("attack_code", enemy ? attack_p : attack_e, mv);
    @(negedge clk);
    old = enemy ? m_hp_p : m_hp_e;
    d   = vld ? dmg : 8'd0;
    nw  = old > d ? old - d : 8'd0;
    if (enemy) m_hp_p = nw; else m_hp_e = nw;
    if (!vld) m_err = 1'b1;
    if (nw == 0) begin m_over = 1'b1; m_win = enemy ? 2'b10 : 2'b01; end
    else if (enemy && m_turn != 8'hff) m_turn++;
    e = '{hp_p: m_hp_p, hp_e: m_hp_e, turn: m_turn, over: m_over, err: m_err, win: m_win,
          lat: vld ? 1 : 15};
    sb.push_back(e);
    // the idle side's valid is pulsed too: it must be ignored
    dmg_e_vld = 1'b1; dmg_p_vld = 1'b1;
    dmg_e = enemy ? 8'd200 : dmg; dmg_p = enemy ? dmg : 8'd200;
    if (enemy) dmg_p_vld = vld; else dmg_e_vld = vld;
    lat = 0;
    do begin
      @(negedge clk);
      dmg_e_vld = 1'b0; dmg_p_vld = 1'b0;
      lat++;
    end while (!(enemy ? (player_turn || game_over) : (e_move_req || game_over)) && lat < 40);
    got = sb.pop_front();
    chk("latency", lat, got.lat);
    chk("hp_p", hp_p_left, got.hp_p);
    chk("hp_e", hp_e_left, got.hp_e);
    chk("turn_cnt", turn_cnt, got.turn);
    chk("game_over", game_over, got.over);
    chk("winner", winner, got.win);
    chk("timeout_err", dmg_timeout_err, got.err);
    chk(enemy ? "back_p_wait" : "e_move_req", enemy ? player_turn : e_move_req, !got.over);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [1:0] prev_ae;
    @(negedge clk);
    #1 chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    turn(0, 2'b01, 8'd20, 1);
    turn(1, 2'b11, 8'd48, 1);
    turn(0, 2'b10, 8'd0, 1);
    prev_ae = attack_e;
    @(negedge clk);
    p_move_valid = 1'b1; start = 1'b1; p_move = 2'b11;
    repeat (2) @(negedge clk);
    p_move_valid = 1'b0; start = 1'b0;
    chk("illegal_en", {att_e_en, att_p_en, player_turn, game_over}, 0);
    chk("illegal_busy", busy, 1);
    chk("illegal_hp", {hp_p_left, hp_e_left}, {m_hp_p, m_hp_e});
    chk("illegal_attack_e", attack_e, prev_ae);
    chk("illegal_turn", turn_cnt, m_turn);
    turn(1, 2'b00, 8'd30, 0);
    turn(0, 2'b11, 8'd72, 1);
    turn(1, 2'b01, 8'd0, 1);
    turn(0, 2'b00, 8'd12, 1);
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("done_hold_hp", {hp_p_left, hp_e_left}, {m_hp_p, m_hp_e});
    chk("done_hold_flags", {game_over, busy, winner, turn_cnt, dmg_timeout_err}, {1'b1, 1'b0, m_win, m_turn, m_err});
    do_start();
    turn(0, 2'b00, 8'd0, 1);
    turn(1, 2'b10, 8'd200, 1);
    do_start();
    p_move_valid = 1'b1; p_move = 2'b11;
    @(negedge clk);
    p_move_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_idle_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_quiet", {att_e_en, att_p_en, busy}, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
